// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder
//   Buffered RV32I encoder for the LW/SW/R-type/BEQ/ADDI/JAL subset. Each
//   accepted request is range-checked, encoded into a 32-bit machine word
//   and queued with a sequential instruction-memory address. Requests whose
//   immediate cannot be represented (or whose kind is illegal) are still
//   handshaken, but they are dropped and raise the sticky err flag.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake
//   in_kind               0=LW 1=SW 2=R 3=BEQ 4=ADDI 5=JAL (6/7 illegal)
//   in_funct              R-type {funct7[5], funct3}
//   in_rd/in_rs1/in_rs2   register indices
//   in_imm                21-bit signed byte offset / immediate
//   out_valid / out_ready word handshake
//   out_instr / out_addr  FIFO head: machine word and its address
//   err                   sticky "illegal request dropped"
//   level                 FIFO occupancy
module rv_instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter int                DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_kind,
  input  logic [3:0]               in_funct,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [20:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  // Immediate fits a 12-bit signed field (I/S formats).
  function automatic logic fits_12(input logic [20:0] imm);
    return (&imm[20:11]) | ~(|imm[20:11]);
  endfunction

  // Immediate fits a 13-bit signed field (B format).
  function automatic logic fits_13(input logic [20:0] imm);
    return (&imm[20:12]) | ~(|imm[20:12]);
  endfunction

  logic [31:0]        enc_instr_s;
  logic               enc_ok_s;
  logic               in_fire_s;
  logic               push_s;
  logic               pop_s;
  logic               drop_s;

  logic [31:0]        mem_instr_r [DEPTH];
  logic [ADDR_W-1:0]  mem_addr_r  [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]   level_r;
  logic [ADDR_W-1:0]  next_addr_r;
  logic               err_r;

  // Encode the current request and decide whether its immediate is legal.
  always_comb begin
    enc_instr_s = 32'h0000_0000;
    enc_ok_s    = 1'b0;
    case (in_kind)
      3'd0: begin
        enc_instr_s = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        enc_ok_s    = fits_12(in_imm);
      end
      3'd1: begin
        enc_instr_s = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        enc_ok_s    = fits_12(in_imm);
      end
      3'd2: begin
        enc_instr_s = {1'b0, in_funct[3], 5'b00000, in_rs2, in_rs1, in_funct[2:0],
                       in_rd, 7'b0110011};
        enc_ok_s    = 1'b1;
      end
      3'd3: begin
        enc_instr_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                       in_imm[4:1], in_imm[11], 7'b1100011};
        enc_ok_s    = fits_13(in_imm) & ~in_imm[0];
      end
      3'd4: begin
        enc_instr_s = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
        enc_ok_s    = fits_12(in_imm);
      end
      3'd5: begin
        enc_instr_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                       in_rd, 7'b1101111};
        enc_ok_s    = ~in_imm[0];
      end
      default: begin
        enc_instr_s = 32'h0000_0000;
        enc_ok_s    = 1'b0;
      end
    endcase
  end

  // No pass-through when full: a pop in the same cycle does not open in_ready.
  assign in_ready  = !reset && (level_r < DEPTH_L);
  assign in_fire_s = in_valid && in_ready;
  assign push_s    = in_fire_s && enc_ok_s;
  assign drop_s    = in_fire_s && !enc_ok_s;
  assign pop_s     = out_valid && out_ready;

  // FIFO storage; reset values make the empty head read as 0 @ BASE_ADDR.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_r[i] <= 32'h0000_0000;
        mem_addr_r[i]  <= BASE_ADDR;
      end
    end else if (push_s) begin
      mem_instr_r[wr_ptr_r] <= enc_instr_s;
      mem_addr_r[wr_ptr_r]  <= next_addr_r;
    end else begin
      mem_instr_r[wr_ptr_r] <= mem_instr_r[wr_ptr_r];
      mem_addr_r[wr_ptr_r]  <= mem_addr_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      if (push_s && !pop_s) begin
        level_r <= level_r + LVL_W'(1);
      end else if (pop_s && !push_s) begin
        level_r <= level_r - LVL_W'(1);
      end else begin
        level_r <= level_r;
      end
    end
  end

  // Next instruction address; dropped requests leave it untouched, wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      next_addr_r <= BASE_ADDR;
    end else if (push_s) begin
      next_addr_r <= next_addr_r + ADDR_W'(4);
    end else begin
      next_addr_r <= next_addr_r;
    end
  end

  // Sticky error flag for dropped requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (drop_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign out_valid = (level_r != {LVL_W{1'b0}});
  assign out_instr = mem_instr_r[rd_ptr_r];
  assign out_addr  = mem_addr_r[rd_ptr_r];
  assign err       = err_r;
  assign level     = level_r;

endmodule
